// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch T-steps, variable-length execute,
// stop/halt and vectored masked interrupts taken at instruction boundaries.
module control_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5,
    parameter int MAX_STEPS    = 16,
    parameter int NUM_IRQ      = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OP = 5'b11011,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_WIDTH    = 16,
    localparam int STEP_W = $clog2(MAX_STEPS),
    localparam int IRQ_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stop,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic [NUM_IRQ-1:0]    irq_mask,
    input  logic                  ien_set,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic [STEP_W-1:0]     exec_steps,
    output logic                  run,
    output logic                  clear,
    output logic [STEP_W-1:0]     step,
    output logic                  fetch,
    output logic                  execute,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  Zin,
    output logic                  Zlo_out,
    output logic                  PCin,
    output logic                  Mem_Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  irq_save,
    output logic                  irq_vec_load,
    output logic [NUM_IRQ-1:0]    irq_ack,
    output logic [IRQ_W-1:0]      irq_vec,
    output logic                  ien,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic [2:0]            state_dbg
);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_IRQ   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [STEP_W-1:0] MAX_EXEC = STEP_W'(MAX_STEPS - 3);

    logic [2:0]              state;
    logic [CLR_W-1:0]        clr_cnt;
    logic [IRQ_W-1:0]        irq_idx;
    logic [STEP_W-1:0]       exec_len;
    logic [STEP_W-1:0]       last_step;
    logic [NUM_IRQ-1:0]      pending;
    logic [IRQ_W-1:0]        pend_idx;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    at_boundary;
    logic                    halt_req;
    logic                    irq_entry;
    logic                    ir_unused;

    assign opcode    = IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
    // Operand bits belong to the datapath; only the opcode matters here.
    assign ir_unused = ^IR[DATA_WIDTH-OPCODE_WIDTH-1:0];

    always_comb begin
        exec_len = exec_steps;
        if (exec_steps == '0) begin
            exec_len = STEP_W'(1);
        end else if (exec_steps > MAX_EXEC) begin
            exec_len = MAX_EXEC;
        end
    end

    assign last_step   = exec_len + STEP_W'(2);
    // >= rather than == so a decoder that shrinks L mid-instruction cannot strand EXEC.
    assign at_boundary = (state == S_EXEC) && (step >= last_step);
    assign halt_req    = stop || (opcode == HALT_OP);
    assign pending     = irq & ~irq_mask;
    assign irq_entry   = at_boundary && !halt_req && ien && (|pending);

    always_comb begin
        pend_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pend_idx = IRQ_W'(i);
            end
        end
    end

    // Moore decode: strobes depend on registered state and step only.
    assign clear        = (state == S_CLEAR);
    assign fetch        = (state == S_FETCH);
    assign execute      = (state == S_EXEC);
    assign run          = fetch || execute || (state == S_IRQ);
    assign irq_save     = (state == S_IRQ) && (step == STEP_W'(0));
    assign irq_vec_load = (state == S_IRQ) && (step == STEP_W'(1));

    assign MARin    = fetch && (step == STEP_W'(0));
    assign IncPC    = MARin;
    assign Zin      = MARin;
    assign PCout    = MARin || irq_save;
    assign Zlo_out  = fetch && (step == STEP_W'(1));
    assign PCin     = Zlo_out;
    assign Mem_Read = Zlo_out;
    assign MDRin    = Zlo_out;
    assign MDRout   = fetch && (step == STEP_W'(2));
    assign IRin     = MDRout;

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            irq_ack[i] = irq_vec_load && (irq_idx == IRQ_W'(i));
        end
    end

    assign irq_vec   = irq_vec_load ? irq_idx : '0;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_CLEAR;
            step        <= '0;
            clr_cnt     <= '0;
            irq_idx     <= '0;
            ien         <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    step <= '0;
                    if (clr_cnt == CLR_LAST) begin
                        state   <= S_FETCH;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                S_FETCH: begin
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(2)) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (at_boundary) begin
                        instr_count <= instr_count + CNT_WIDTH'(1);
                        step        <= '0;
                        if (halt_req) begin
                            state <= S_HALT;
                        end else if (irq_entry) begin
                            state   <= S_IRQ;
                            irq_idx <= pend_idx;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_IRQ: begin
                    if (step == STEP_W'(1)) begin
                        state <= S_FETCH;
                        step  <= '0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_HALT: begin
                    step <= '0;
                end
                default: begin
                    state <= S_CLEAR;
                    step  <= '0;
                end
            endcase

            // Entry clears ien even if the decoder re-enables in the same cycle.
            if (irq_entry) begin
                ien <= 1'b0;
            end else if (ien_set && (state != S_CLEAR)) begin
                ien <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table of instructions driven from
// FETCH T0, expected results queued at stimulus and compared at the next boundary.
module tb_control_sequencer;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int MS = 16;
    localparam int NI = 4;
    localparam int SW = 4;
    localparam int IW = 2;
    localparam int CW = 16;

    localparam logic [11:0] T0_PAT   = 12'b1111_0000_0000;
    localparam logic [11:0] T1_PAT   = 12'b0000_1111_0000;
    localparam logic [11:0] T2_PAT   = 12'b0000_0000_1100;
    localparam logic [11:0] IRQ0_PAT = 12'b1000_0000_0010;
    localparam logic [11:0] IRQ1_PAT = 12'b0000_0000_0001;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stop = 1'b0;
    logic          ien_set = 1'b0;
    logic [NI-1:0] irq = '0;
    logic [NI-1:0] irq_mask = '0;
    logic [DW-1:0] IR = '0;
    logic [SW-1:0] exec_steps = '0;

    logic          run, clear, fetch, execute;
    logic [SW-1:0] step;
    logic          PCout, MARin, IncPC, Zin, Zlo_out, PCin, Mem_Read, MDRin, MDRout, IRin;
    logic          irq_save, irq_vec_load, ien;
    logic [NI-1:0] irq_ack;
    logic [IW-1:0] irq_vec;
    logic [CW-1:0] instr_count;
    logic [2:0]    state_dbg;

    control_sequencer #(
        .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .MAX_STEPS(MS), .NUM_IRQ(NI),
        .HALT_OP(5'b11011), .CLEAR_CYCLES(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .stop(stop), .irq(irq), .irq_mask(irq_mask),
        .ien_set(ien_set), .IR(IR), .exec_steps(exec_steps),
        .run(run), .clear(clear), .step(step), .fetch(fetch), .execute(execute),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlo_out(Zlo_out),
        .PCin(PCin), .Mem_Read(Mem_Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .irq_save(irq_save), .irq_vec_load(irq_vec_load), .irq_ack(irq_ack),
        .irq_vec(irq_vec), .ien(ien), .instr_count(instr_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] steps;
        logic [3:0] irq;
        logic [3:0] mask;
        logic       set_ien;
        logic       set_late;
        int         len;
        logic       took_irq;
        logic [3:0] ack;
        logic [1:0] vec;
        logic       ien_after;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] exp_q[$];
    logic [15:0] cnt_model;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [11:0] strobes();
        return {PCout, MARin, IncPC, Zin, Zlo_out, PCin, Mem_Read, MDRin,
                MDRout, IRin, irq_save, irq_vec_load};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Holds reset, checks reset values, releases it at a falling edge and
    // returns at the falling edge where FETCH T0 should be visible.
    task automatic do_reset();
        reset = 1'b0;
        stop = 1'b0;
        ien_set = 1'b0;
        irq = '0;
        irq_mask = '0;
        IR = '0;
        exec_steps = '0;
        repeat (2) @(negedge clk);
        check("rst_clear_run", {clear, run}, 2'b10);
        check("rst_step", step, 0);
        check("rst_strobes", strobes(), 0);
        check("rst_irq_out", {irq_ack, irq_vec, ien}, 0);
        check("rst_count", instr_count, 0);
        reset = 1'b1;
        cnt_model = '0;
        #1;
        check("clear_cycle1", {clear, run, fetch}, 3'b100);
        @(negedge clk);
        check("clear_cycle2", {clear, run, fetch}, 3'b100);
        @(negedge clk);
        check("first_t0", {clear, run, fetch, step, strobes()}, {1'b0, 1'b1, 1'b1, 4'd0, T0_PAT});
    endtask

    // Runs one instruction starting at FETCH T0 and compares at the next T0.
    task automatic run_instr(input vec_t v, input bit stop_t1, input logic [DW-1:0] ir_val);
        int          cyc;
        int          last_cyc;
        bit          seq_ok;
        bit          saw_irq;
        bit          done;
        logic [3:0]  ack_seen;
        logic [1:0]  vec_seen;
        logic [31:0] exp;

        exec_steps = v.steps;
        irq = v.irq;
        irq_mask = v.mask;
        ien_set = v.set_ien;
        IR = ir_val;
        cnt_model = cnt_model + 16'd1;
        exp_q.push_back({8'(v.len), v.took_irq, v.ack, v.vec, v.ien_after, cnt_model});

        last_cyc = v.len - 1 - (v.took_irq ? 2 : 0);
        seq_ok = fetch && (step == 4'd0) && (strobes() == T0_PAT);
        saw_irq = 1'b0;
        done = 1'b0;
        ack_seen = '0;
        vec_seen = '0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ien_set = v.set_late && (cyc == last_cyc);
            stop = stop_t1 && (cyc == 1);
            if (fetch && step == 4'd0) begin
                done = 1'b1;
            end else if (cyc == 1) begin
                seq_ok = seq_ok && fetch && (step == 4'd1) && (strobes() == T1_PAT);
            end else if (cyc == 2) begin
                seq_ok = seq_ok && fetch && (step == 4'd2) && (strobes() == T2_PAT);
            end else if (execute) begin
                seq_ok = seq_ok && (int'(step) == cyc) && (strobes() == 12'd0) && run;
            end else if (irq_save) begin
                saw_irq = 1'b1;
                seq_ok = seq_ok && (strobes() == IRQ0_PAT) && run;
            end else if (irq_vec_load) begin
                ack_seen = irq_ack;
                vec_seen = irq_vec;
                seq_ok = seq_ok && (strobes() == IRQ1_PAT) && run;
            end else begin
                seq_ok = 1'b0;
            end
        end
        ien_set = 1'b0;
        stop = 1'b0;

        exp = exp_q.pop_front();
        check("instr_len", cyc, {24'd0, exp[31:24]});
        check("irq_taken", saw_irq, exp[23]);
        check("irq_ack", ack_seen, exp[22:19]);
        check("irq_vec", vec_seen, exp[18:17]);
        check("ien_after", ien, exp[16]);
        check("instr_count", instr_count, exp[15:0]);
        check("step_sequence", seq_ok, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        steps  irq      mask     ien  late len irq  ack      vec ien_after
        tbl[0]  = '{4'd3,  4'b0000, 4'b0000, 1'b0, 1'b0, 6,  1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 4,  1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{4'd15, 4'b0000, 4'b0000, 1'b0, 1'b0, 16, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'd13, 4'b0000, 4'b0000, 1'b0, 1'b0, 16, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[4]  = '{4'd1,  4'b0000, 4'b0000, 1'b0, 1'b0, 4,  1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[5]  = '{4'd7,  4'b0110, 4'b0010, 1'b1, 1'b0, 12, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[6]  = '{4'd2,  4'b1111, 4'b0000, 1'b0, 1'b0, 5,  1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[7]  = '{4'd2,  4'b1000, 4'b1000, 1'b1, 1'b0, 5,  1'b0, 4'b0000, 2'd0, 1'b1};
        tbl[8]  = '{4'd5,  4'b1001, 4'b0000, 1'b0, 1'b0, 10, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[9]  = '{4'd4,  4'b1100, 4'b0100, 1'b1, 1'b0, 9,  1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[10] = '{4'd14, 4'b0000, 4'b0000, 1'b0, 1'b0, 16, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{4'd3,  4'b0001, 4'b0000, 1'b1, 1'b1, 8,  1'b1, 4'b0001, 2'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i], 1'b0, 32'(($urandom_range(0, 26)) << 27) | 32'($urandom_range(0, 1000)));
        end

        // stop pulsed only at T1 must not halt
        run_instr('{4'd2, 4'b0000, 4'b0000, 1'b0, 1'b0, 5, 1'b0, 4'b0000, 2'd0, 1'b0}, 1'b1, '0);

        // stop held through the last execute step
        exec_steps = 4'd2;
        irq = '0;
        stop = 1'b1;
        cnt_model = cnt_model + 16'd1;
        repeat (5) @(negedge clk);
        check("stop_halt_outputs", {run, clear, fetch, execute, step, strobes()}, 0);
        check("stop_halt_state", state_dbg, 3'd4);
        check("stop_halt_count", instr_count, cnt_model);
        stop = 1'b0;
        ien_set = 1'b1;
        @(negedge clk);
        ien_set = 1'b0;
        repeat (4) @(negedge clk);
        check("halt_persists", {run, fetch, execute, strobes(), state_dbg}, {3'b000, 12'd0, 3'd4});

        // HALT opcode completes its execute phase then halts
        do_reset();
        IR = {5'b11011, 27'h0123456};
        exec_steps = 4'd1;
        cnt_model = cnt_model + 16'd1;
        repeat (3) @(negedge clk);
        check("haltop_last_step", {execute, step}, {1'b1, 4'd3});
        @(negedge clk);
        check("haltop_halted", {run, fetch, execute, strobes(), state_dbg}, {3'b000, 12'd0, 3'd4});
        check("haltop_count", instr_count, cnt_model);
        repeat (3) @(negedge clk);
        check("haltop_stays", {run, state_dbg}, {1'b0, 3'd4});

        // reset asserted at EXEC step 4 takes effect without a clock edge
        do_reset();
        run_instr(tbl[0], 1'b0, '0);
        exec_steps = 4'd5;
        repeat (4) @(negedge clk);
        check("pre_reset_step4", {execute, step}, {1'b1, 4'd4});
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {clear, run, fetch, execute, step, strobes()}, {4'b1000, 4'd0, 12'd0});
        check("async_reset_count", instr_count, 0);
        do_reset();
        run_instr(tbl[1], 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the MiniSRC-class CPU. It generates T-step timing and fetch control strobes, and runs a variable-length execute phase sized by the opcode decoder. It also handles stop/halt and vectored, masked interrupts at instruction boundaries, and counts retired instructions. It sits between the datapath (IR, register file, memory interface) and the opcode decoder, which supplies execute-phase strobes keyed on `step`.

## Interface
- DATA_WIDTH, 32, IR width
- OPCODE_WIDTH, 5, opcode field width (IR MSBs)
- MAX_STEPS, 16, total T-steps per instruction including 3 fetch steps; STEP_W = clog2(MAX_STEPS)
- NUM_IRQ, 4, interrupt lines; IRQ_W = clog2(NUM_IRQ), minimum 1
- HALT_OP, 5'b11011, opcode that halts after its execute phase
- CLEAR_CYCLES, 2, cycles `clear` is held after reset release
- CNT_WIDTH, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- stop  in  1  halt request, level
- irq  in  NUM_IRQ  interrupt requests, level
- irq_mask  in  NUM_IRQ  1 = line masked
- ien_set  in  1  decoder pulse that re-enables interrupts
- IR  in  DATA_WIDTH  instruction register contents
- exec_steps  in  STEP_W  execute length for the current IR, from the decoder
- run  out  1  CPU running
- clear  out  1  datapath clear
- step  out  STEP_W  current T-step
- fetch, execute  out  1  phase flags
- PCout, MARin, IncPC, Zin, Zlo_out, PCin, Mem_Read, MDRin, MDRout, IRin  out  1  fetch strobes
- irq_save, irq_vec_load  out  1  interrupt entry strobes
- irq_ack  out  NUM_IRQ  one-hot acknowledge
- irq_vec  out  IRQ_W  index of the serviced line
- ien  out  1  interrupt enable
- instr_count  out  CNT_WIDTH  retired instructions

## Operation
- States: CLEAR, FETCH, EXEC, IRQ, HALT. Moore outputs: every strobe is decoded from registered state and `step` only.
- CLEAR: `clear`=1 and `run`=0 for CLEAR_CYCLES cycles, then go to FETCH with step 0.
- FETCH:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlo_out, PCin, Mem_Read, MDRin.
  - T2: MDRout, IRin.
  - Then go to EXEC with step 3.
- EXEC:
  - `step` increments each cycle.
  - Effective length L is `exec_steps` sampled every cycle (IR is stable). `exec_steps`=0 is treated as 1. L is saturated to MAX_STEPS-3.
  - The last execute step is step == 2+L. At that step `instr_count` increments (wraps modulo 2^CNT_WIDTH), and the next state is chosen at the boundary by priority:
    1. `stop`=1, or IR opcode == HALT_OP → HALT.
    2. `ien`=1 and (irq & ~irq_mask) ≠ 0 → IRQ.
    3. Otherwise → FETCH, step 0.
- IRQ (2 steps):
  - Step 0: irq_save, PCout.
  - Step 1: irq_vec_load, `irq_ack` one-hot for the lowest-index pending unmasked line, `irq_vec` = that index.
  - The line is latched on IRQ entry and held stable through IRQ.
  - `ien` is cleared on IRQ entry and set again by `ien_set` (a pulse in any state except CLEAR).
  - Then go to FETCH.
- HALT: `run`=0, all strobes 0. Only reset exits HALT.
- `stop` is ignored mid-instruction; it acts only at the boundary.
- `irq` lines dropping during IRQ do not cancel entry.

## Timing
- Reset values (asynchronous, while reset=0): state CLEAR, step 0, clear=1, run=0, all strobes 0, irq_ack=0, irq_vec=0, ien=0, instr_count=0.
- `run`=1 in FETCH, EXEC and IRQ.
- Instruction latency is 3+L cycles without an interrupt, plus 2 cycles with one.
- Minimum instruction length is 4 cycles.
- First FETCH T0 occurs CLEAR_CYCLES cycles after reset rises.
- Reset asserted mid-instruction forces CLEAR immediately with no retire count.
- `ien_set` and IRQ entry in the same cycle: entry wins, and `ien` ends at 0.

## Test plan
- Reset release, `exec_steps`=3, no irq → clear high for 2 cycles; T0 strobes (PCout/MARin/IncPC/Zin) in cycle 3; IRin at step 2; steps 3,4,5; instr_count=1 at step 0 of the next instruction.
- `exec_steps`=0, then 15 with MAX_STEPS=16 → the first instruction lasts 4 cycles; the second saturates at the last step 15 (L=13) and wraps step to 0.
- `ien` set, irq=4'b0110, mask=4'b0010 during EXEC → after the last step: irq_save, then irq_vec_load with irq_ack=4'b0100 and irq_vec=2; ien=0; FETCH resumes.
- `stop` pulsed at FETCH T1 for 1 cycle only → no halt. `stop` held through the last execute step → HALT, run=0, strobes 0 until reset.
- IR opcode = 5'b11011 → execute phase completes, instr_count increments, then HALT.
- Reset dropped at EXEC step 4 → all outputs take reset values in the same cycle (asynchronous); instr_count=0; the sequence restarts from CLEAR.
